wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two requesters:
  - the in-order pipeline write-back result (after the MemtoReg select);
  - a late requester (multi-cycle unit / debug writer).
- The pipeline has priority and no backpressure.
- Late writes queue in a small FIFO.
- A starvation timer forces a one-cycle pipeline stall so the queued write can drain.
- Sits between the write-back stage and the register bank; drives the bank's write port through registered outputs.

---
 rtl/wb_port_arbiter_if.sv | 46 ++++
 rtl/wb_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_wb_port_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Write-back port bundle shared by the pipeline, the late requester and the register bank.
// WB_ARB_STATS_EN adds the stall/drop statistics outputs.
interface wb_port_arbiter_if #(
  parameter int unsigned B     = 32,
  parameter int unsigned D     = 5,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            pipe_we;
  logic [D-1:0]    pipe_waddr;
  logic [B-1:0]    pipe_wdata;
  logic            late_valid;
  logic            late_ready;
  logic [D-1:0]    late_waddr;
  logic [B-1:0]    late_wdata;
  logic            stall_pipe;
  logic            rf_we;
  logic [D-1:0]    rf_waddr;
  logic [B-1:0]    rf_wdata;
  logic [CntW-1:0] late_pending;
`ifdef WB_ARB_STATS_EN
  logic [15:0]     stall_count;
  logic [15:0]     drop_count;
`endif

  // Requesters and register bank side.
  modport master (
    output pipe_we, pipe_waddr, pipe_wdata,
    output late_valid, late_waddr, late_wdata,
    input  late_ready, stall_pipe, rf_we, rf_waddr, rf_wdata, late_pending
`ifdef WB_ARB_STATS_EN
    , input stall_count, drop_count
`endif
  );

  // Arbiter side.
  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata,
    input  late_valid, late_waddr, late_wdata,
    output late_ready, stall_pipe, rf_we, rf_waddr, rf_wdata, late_pending
`ifdef WB_ARB_STATS_EN
    , output stall_count, drop_count
`endif
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority, late writes queue in a FIFO
// and a starvation timer forces a one-cycle pipeline stall. WB_ARB_STATS_EN adds statistics.
module wb_port_arbiter #(
  parameter int unsigned B        = 32,
  parameter int unsigned D        = 5,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 8
) (
  input logic              clk,
  input logic              reset,
  wb_port_arbiter_if.slave bus
);
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned WaitW = $clog2(MAX_WAIT) + 1;

  logic [D-1:0]     addr_mem_q [DEPTH];
  logic [B-1:0]     data_mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             stall_q, stall_d;
  logic             rf_we_q, rf_we_d;
  logic [D-1:0]     rf_waddr_q, rf_waddr_d;
  logic [B-1:0]     rf_wdata_q, rf_wdata_d;

  logic         full, not_empty, push, pop;
  logic [D-1:0] head_addr;
  logic [B-1:0] head_data;

  assign full      = (count_q == CntW'(DEPTH));
  assign not_empty = (count_q != '0);
  assign head_addr = addr_mem_q[rd_ptr_q];
  assign head_data = data_mem_q[rd_ptr_q];
  // Register-0 writes complete the handshake but never occupy a slot.
  assign push      = bus.late_valid && !full && (bus.late_waddr != '0);

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    pop        = 1'b0;
    if (stall_q) begin
      if (not_empty) begin
        pop        = 1'b1;
        rf_we_d    = 1'b1;
        rf_waddr_d = head_addr;
        rf_wdata_d = head_data;
      end
    end else if (bus.pipe_we) begin
      if (bus.pipe_waddr != '0) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = bus.pipe_waddr;
        rf_wdata_d = bus.pipe_wdata;
        // The pipeline write is younger, so a queued write to the same register is dead.
        if (not_empty && (head_addr == bus.pipe_waddr)) pop = 1'b1;
      end
    end else if (not_empty) begin
      pop        = 1'b1;
      rf_we_d    = 1'b1;
      rf_waddr_d = head_addr;
      rf_wdata_d = head_data;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    stall_d = 1'b0;
    wait_d  = wait_q;
    if (!not_empty || pop) begin
      wait_d = '0;
    end else if (wait_q == WaitW'(MAX_WAIT - 1)) begin
      stall_d = 1'b1;
      wait_d  = '0;
    end else begin
      wait_d = wait_q + WaitW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wait_q     <= '0;
      stall_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wait_q     <= wait_d;
      stall_q    <= stall_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= bus.late_waddr;
      data_mem_q[wr_ptr_q] <= bus.late_wdata;
    end
  end

  assign bus.late_ready   = !full;
  assign bus.stall_pipe   = stall_q;
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_waddr     = rf_waddr_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.late_pending = count_q;

`ifdef WB_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [16:0] drop_sum;
  logic        supersede, reg0_drop;

  assign supersede = !stall_q && bus.pipe_we && (bus.pipe_waddr != '0) && not_empty &&
                     (head_addr == bus.pipe_waddr);
  assign reg0_drop = bus.late_valid && !full && (bus.late_waddr == '0);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_q && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    // Both drop sources can fire together, so saturate on a widened sum.
    drop_sum   = {1'b0, drop_cnt_q} + 17'(supersede) + 17'(reg0_drop);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign bus.stall_count = stall_cnt_q;
  assign bus.drop_count  = drop_cnt_q;
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: expected register-file writes are queued as stimulus is
// driven and matched by a monitor on every rf_we cycle.
module tb_wb_port_arbiter;
  localparam int unsigned B        = 32;
  localparam int unsigned D        = 5;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAX_WAIT = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.B(B), .D(D), .DEPTH(DEPTH)) bus ();

  wb_port_arbiter #(
    .B        (B),
    .D        (D),
    .DEPTH    (DEPTH),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned    n_checks = 0;
  int unsigned    n_errors = 0;
  logic [D+B-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every cycle with rf_we high must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (bus.rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(bus.rf_waddr), 64'hFFFF_FFFF);
      end else begin
        logic [D+B-1:0] e;
        e = exp_q.pop_front();
        check("rf_write", 64'({bus.rf_waddr, bus.rf_wdata}), 64'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic we, input logic [D-1:0] a, input logic [B-1:0] d);
    bus.pipe_we    = we;
    bus.pipe_waddr = a;
    bus.pipe_wdata = d;
  endtask

  task automatic late(input logic v, input logic [D-1:0] a, input logic [B-1:0] d);
    bus.late_valid = v;
    bus.late_waddr = a;
    bus.late_wdata = d;
  endtask

  task automatic expect_wr(input logic [D-1:0] a, input logic [B-1:0] d);
    exp_q.push_back({a, d});
  endtask

  initial begin
    reset = 1'b0;
    pipe(1'b0, '0, '0);
    late(1'b0, '0, '0);
    #12;
    check("rst_rf_we", 64'(bus.rf_we), 64'd0);
    check("rst_stall", 64'(bus.stall_pipe), 64'd0);
    check("rst_pending", 64'(bus.late_pending), 64'd0);
    check("rst_waddr", 64'(bus.rf_waddr), 64'd0);
    check("rst_wdata", 64'(bus.rf_wdata), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("rst_ready", 64'(bus.late_ready), 64'd1);

    // Single pipeline write, one-cycle latency, one-cycle pulse.
    pipe(1'b1, 5'd3, 32'hDEADBEEF);
    expect_wr(5'd3, 32'hDEADBEEF);
    tick();
    pipe(1'b0, '0, '0);
    check("t1_we_hi", 64'(bus.rf_we), 64'd1);
    tick();
    check("t1_we_lo", 64'(bus.rf_we), 64'd0);

    // Back-to-back late pushes with the pipeline idle.
    late(1'b1, 5'd5, 32'h11);
    expect_wr(5'd5, 32'h11);
    tick();
    check("t2_pend0", 64'(bus.late_pending), 64'd1);
    check("t2_we0", 64'(bus.rf_we), 64'd0);
    late(1'b1, 5'd6, 32'h22);
    expect_wr(5'd6, 32'h22);
    tick();
    late(1'b0, '0, '0);
    check("t2_pend1", 64'(bus.late_pending), 64'd1);
    check("t2_we1", 64'(bus.rf_we), 64'd1);
    tick();
    check("t2_pend2", 64'(bus.late_pending), 64'd0);
    tick();

    // Pipeline busy every cycle: starvation stall after MAX_WAIT denials.
    for (int i = 0; i <= 10; i++) begin
      check("t3_stall", 64'(bus.stall_pipe), 64'(i == 9));
      pipe(1'b1, 5'd7, 32'h700 + 32'(i));
      if (i == 0) late(1'b1, 5'd9, 32'hA5);
      else late(1'b0, '0, '0);
      if (i == 9) expect_wr(5'd9, 32'hA5);
      else expect_wr(5'd7, 32'h700 + 32'(i));
      tick();
    end
    pipe(1'b0, '0, '0);
    check("t3_pend", 64'(bus.late_pending), 64'd0);
`ifdef WB_ARB_STATS_EN
    check("t3_stall_count", 64'(bus.stall_count), 64'd1);
`endif
    tick();

    // Queued write superseded by a younger pipeline write to the same register.
    late(1'b1, 5'd4, 32'h1);
    tick();
    late(1'b0, '0, '0);
    check("t4_pend1", 64'(bus.late_pending), 64'd1);
    pipe(1'b1, 5'd4, 32'h2);
    expect_wr(5'd4, 32'h2);
    tick();
    pipe(1'b0, '0, '0);
    check("t4_pend0", 64'(bus.late_pending), 64'd0);
    tick();
    tick();
`ifdef WB_ARB_STATS_EN
    check("t4_drop_count", 64'(bus.drop_count), 64'd1);
`endif

    // Fill the FIFO under a busy pipeline; a fifth request waits until the stall pops one.
    for (int i = 0; i <= 10; i++) begin
      if (i >= 4) begin
        check("t5_ready", 64'(bus.late_ready), 64'(i == 10));
        check("t5_pending", 64'(bus.late_pending), (i == 10) ? 64'd3 : 64'd4);
      end
      pipe(1'b1, 5'd8, 32'h800 + 32'(i));
      if (i < 4) late(1'b1, 5'(10 + i), 32'hA0 + 32'(i));
      else late(1'b1, 5'd14, 32'hA4);
      if (i == 9) expect_wr(5'd10, 32'hA0);
      else expect_wr(5'd8, 32'h800 + 32'(i));
      tick();
    end
    pipe(1'b0, '0, '0);
    late(1'b0, '0, '0);
    check("t5_pend_last", 64'(bus.late_pending), 64'd4);
    for (int k = 1; k <= 4; k++) expect_wr(5'(10 + k), 32'hA0 + 32'(k));
    for (int k = 0; k < 6; k++) tick();
    check("t5_drained", 64'(bus.late_pending), 64'd0);
    late(1'b1, 5'd0, 32'hBAD);
    check("t5_r0_ready", 64'(bus.late_ready), 64'd1);
    tick();
    late(1'b0, '0, '0);
    check("t5_r0_pend", 64'(bus.late_pending), 64'd0);
    tick();
    tick();
`ifdef WB_ARB_STATS_EN
    check("t5_drop_count", 64'(bus.drop_count), 64'd2);
`endif

    // Asynchronous reset while three entries wait and the stall is active.
    for (int i = 0; i <= 8; i++) begin
      pipe(1'b1, 5'd7, 32'h600 + 32'(i));
      if (i < 3) late(1'b1, 5'(20 + i), 32'hB0 + 32'(i));
      else late(1'b0, '0, '0);
      if (i <= 7) expect_wr(5'd7, 32'h600 + 32'(i));
      tick();
    end
    check("t6_pre_stall", 64'(bus.stall_pipe), 64'd1);
    check("t6_pre_pend", 64'(bus.late_pending), 64'd3);
    check("t6_pre_we", 64'(bus.rf_we), 64'd1);
    #1;
    reset = 1'b0;
    #1;
    check("t6_rst_we", 64'(bus.rf_we), 64'd0);
    check("t6_rst_stall", 64'(bus.stall_pipe), 64'd0);
    check("t6_rst_pend", 64'(bus.late_pending), 64'd0);
    pipe(1'b0, '0, '0);
    late(1'b0, '0, '0);
    tick();
    tick();
    reset = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    check("t6_post_pend", 64'(bus.late_pending), 64'd0);
    check("t6_post_stall", 64'(bus.stall_pipe), 64'd0);
    check("t6_post_ready", 64'(bus.late_ready), 64'd1);
`ifdef WB_ARB_STATS_EN
    check("t6_stall_count", 64'(bus.stall_count), 64'd0);
`endif
    check("exp_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
